// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results take the regfile port, loads wait in a FIFO.
// Define WB_BYPASS_EN to let a load with an empty queue skip the FIFO.
module wb_arbiter #(
  parameter int QLOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_we,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  input  logic [4:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic [4:0]  q_addr1,
  input  logic [4:0]  q_addr2,
  output logic        busy1,
  output logic        busy2,
  output logic        stall,
  output logic        overflow,
  output logic        rf_we,
  output logic [4:0]  rf_addrw,
  output logic [31:0] rf_wdata
);

  localparam int DEPTH = 1 << QLOG2;
  localparam int PW    = (QLOG2 > 0) ? QLOG2 : 1;
  localparam int CW    = QLOG2 + 1;

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [4:0]       qa_q [DEPTH];
  logic [31:0]      qd_q [DEPTH];
  logic             ovf_q, ovf_d;
  logic             we_q, we_d;
  logic [4:0]       addr_q, addr_d;
  logic [31:0]      data_q, data_d;

  logic alu_ok, ld_ok, empty, full;
  logic pop, push, drop, bypass;

  // Registers 0, 1 and 31 are hardwired in the regfile.
  function automatic logic legal(input logic [4:0] a);
    return !(a == 5'd0 || a == 5'd1 || a == 5'd31);
  endfunction

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    alu_ok = alu_we && legal(alu_addr);
    ld_ok  = ld_valid && legal(ld_addr);
    empty  = (cnt_q == '0);
    full   = (cnt_q == CW'(DEPTH));
    pop    = !alu_ok && !empty;
`ifdef WB_BYPASS_EN
    bypass = ld_ok && !alu_ok && empty;
`else
    bypass = 1'b0;
`endif
    push   = ld_ok && !bypass && (!full || pop);
    drop   = ld_ok && !bypass && full && !pop;
  end

  always_comb begin
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    ovf_d  = ovf_q | drop;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    // Younger ALU value wins over queued loads to the same register.
    if (alu_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && qa_q[i] == alu_addr) vld_d[i] = 1'b0;
      end
    end
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = nxt(head_q);
    end
    if (push) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = nxt(tail_q);
    end
    unique case (1'b1)
      alu_ok: begin
        we_d   = 1'b1;
        addr_d = alu_addr;
        data_d = alu_data;
      end
      pop: begin
        we_d = vld_q[head_q];
        if (vld_q[head_q]) begin
          addr_d = qa_q[head_q];
          data_d = qd_q[head_q];
        end
      end
      bypass: begin
        we_d   = 1'b1;
        addr_d = ld_addr;
        data_d = ld_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      ovf_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qa_q[tail_q] <= ld_addr;
      qd_q[tail_q] <= ld_data;
    end
  end

  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && qa_q[i] == q_addr1) busy1 = 1'b1;
      if (vld_q[i] && qa_q[i] == q_addr2) busy2 = 1'b1;
    end
    busy1 = busy1 && legal(q_addr1);
    busy2 = busy2 && legal(q_addr2);
  end

  assign stall    = (cnt_q != '0) && (cnt_q >= CW'(DEPTH - 1));
  assign overflow = ovf_q;
  assign rf_we    = we_q;
  assign rf_addrw = addr_q;
  assign rf_wdata = data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected regfile writes are queued,
// a negedge monitor pops and compares each write it observes.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_we;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [4:0]  q_addr1, q_addr2;
  logic        busy1, busy2, stall, overflow;
  logic        rf_we;
  logic [4:0]  rf_addrw;
  logic [31:0] rf_wdata;

  wb_arbiter #(.QLOG2(2)) dut (
    .clk(clk), .rst(rst),
    .alu_we(alu_we), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .q_addr1(q_addr1), .q_addr2(q_addr2),
    .busy1(busy1), .busy2(busy2), .stall(stall), .overflow(overflow),
    .rf_we(rf_we), .rf_addrw(rf_addrw), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef WB_BYPASS_EN
  localparam int LD_LAT = 1;
`else
  localparam int LD_LAT = 2;
`endif

  typedef struct {
    int          c;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  n;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expw(input int c, input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.c = c;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic drive(input logic aw, input logic [4:0] aa,
                       input logic [31:0] ad, input logic lv,
                       input logic [4:0] la, input logic [31:0] ldd);
    @(posedge clk);
    #1;
    alu_we   = aw;
    alu_addr = aa;
    alu_data = ad;
    ld_valid = lv;
    ld_addr  = la;
    ld_data  = ldd;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (!rst && rf_we) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got r%0d=0x%0h at cycle %0d, expected none",
                 rf_addrw, rf_wdata, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_cycle", cyc, mon_e.c);
        chk("wr_addr", {27'd0, rf_addrw}, {27'd0, mon_e.a});
        chk("wr_data", rf_wdata, mon_e.d);
      end
    end
  end

  initial begin
    rst = 1'b1;
    alu_we = 0; alu_addr = 0; alu_data = 0;
    ld_valid = 0; ld_addr = 0; ld_data = 0;
    q_addr1 = 0; q_addr2 = 0;
    #1;
    chk("rst_we", rf_we, 1'b0);
    chk("rst_addrw", rf_addrw, 5'd0);
    chk("rst_wdata", rf_wdata, 32'h0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_stall", stall, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    q_addr1 = 5'd6;
    drive(1, 5'd5, 32'h11, 1, 5'd6, 32'h22);
    n = cyc;
    expw(n + 1, 5'd5, 32'h11);
    expw(n + 2, 5'd6, 32'h22);
    idle(); #1 chk("prio_busy_n1", busy1, 1'b1);
    idle(); #1 chk("prio_busy_n2", busy1, 1'b0);
    idle();

    q_addr2 = 5'd7;
    drive(1, 5'd2, 32'h1, 1, 5'd7, 32'hAA);
    n = cyc;
    expw(n + 1, 5'd2, 32'h1);
    drive(1, 5'd7, 32'hBB, 0, 5'd0, 32'h0);
    expw(n + 2, 5'd7, 32'hBB);
    #1 chk("sq_busy_queued", busy2, 1'b1);
    idle(); #1 chk("sq_busy_cleared", busy2, 1'b0);
    idle(); #1;
    chk("sq_pop_we", rf_we, 1'b0);
    chk("sq_hold_addr", {27'd0, rf_addrw}, 32'd7);
    chk("sq_hold_data", rf_wdata, 32'hBB);

    q_addr1 = 5'd31;
    drive(1, 5'd0, 32'h1, 1, 5'd31, 32'h2);
    drive(1, 5'd1, 32'h3, 0, 5'd0, 32'h0);
    drive(1, 5'd31, 32'h4, 1, 5'd31, 32'h5);
    idle(); #1;
    chk("filt_we", rf_we, 1'b0);
    chk("filt_busy31", busy1, 1'b0);
    chk("filt_stall", stall, 1'b0);
    idle();

    drive(0, 5'd0, 32'h0, 1, 5'd9, 32'h5);
    n = cyc;
    expw(n + LD_LAT, 5'd9, 32'h5);
    idle(); idle(); idle();

    q_addr1 = 5'd16;
    q_addr2 = 5'd20;
    drive(1, 5'd10, 32'h100, 1, 5'd16, 32'h160);
    n = cyc;
    expw(n + 1, 5'd10, 32'h100);
    drive(1, 5'd11, 32'h101, 1, 5'd17, 32'h161);
    expw(n + 2, 5'd11, 32'h101);
    #1 chk("full_stall_c1", stall, 1'b0);
    drive(1, 5'd12, 32'h102, 1, 5'd18, 32'h162);
    expw(n + 3, 5'd12, 32'h102);
    #1 chk("full_stall_c2", stall, 1'b0);
    drive(1, 5'd13, 32'h103, 1, 5'd19, 32'h163);
    expw(n + 4, 5'd13, 32'h103);
    #1 chk("full_stall_c3", stall, 1'b1);
    drive(1, 5'd14, 32'h104, 1, 5'd20, 32'h164);
    expw(n + 5, 5'd14, 32'h104);
    #1 chk("full_stall_c4", stall, 1'b1);
    chk("full_ovf_before", overflow, 1'b0);
    drive(1, 5'd15, 32'h105, 0, 5'd0, 32'h0);
    expw(n + 6, 5'd15, 32'h105);
    #1 chk("full_ovf_set", overflow, 1'b1);
    chk("full_busy_head", busy1, 1'b1);
    chk("full_busy_dropped", busy2, 1'b0);
    expw(n + 7, 5'd16, 32'h160);
    expw(n + 8, 5'd17, 32'h161);
    expw(n + 9, 5'd18, 32'h162);
    expw(n + 10, 5'd19, 32'h163);
    idle(); #1 chk("drain_stall4", stall, 1'b1);
    idle(); #1 chk("drain_stall3", stall, 1'b1);
    idle(); #1 chk("drain_stall2", stall, 1'b0);
    idle(); idle(); idle();
    #1 chk("ovf_sticky", overflow, 1'b1);

    q_addr1 = 5'd21;
    drive(1, 5'd3, 32'h30, 1, 5'd21, 32'h210);
    n = cyc;
    expw(n + 1, 5'd3, 32'h30);
    drive(1, 5'd4, 32'h40, 1, 5'd22, 32'h220);
    expw(n + 2, 5'd4, 32'h40);
    drive(1, 5'd5, 32'h50, 1, 5'd23, 32'h230);
    expw(n + 3, 5'd5, 32'h50);
    idle(); #1;
    chk("mid_stall_pre", stall, 1'b1);
    chk("mid_busy_pre", busy1, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we", rf_we, 1'b0);
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_busy", busy1, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    #1 rst = 1'b0;
    idle(); idle(); idle(); idle();

    #1 chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
